// File: rtl/fde_machine.sv
// Fetch-decode-execute phase sequencer with one-hot phase strobes.
// Define FDE_COUNT_EN to add the retired-instruction counter and its instr_count port.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no instruction in flight; waits for halt=0
// FETCH   | instruction fetch phase
// DECODE  | instruction decode phase
// EXECUTE | execute phase; retires when en=1
module fde_machine #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               halt,
    output logic [1:0]         state,
    output logic               fetch,
    output logic               decode,
    output logic               execute,
    output logic               instr_done
`ifdef FDE_COUNT_EN
    ,
    output logic [COUNT_W-1:0] instr_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DECODE  = 2'b10,
        ST_EXECUTE = 2'b11
    } phase_t;

    phase_t state_q;
    phase_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // halt only matters at the phase boundaries where a new fetch could start
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_IDLE:    state_d = halt ? ST_IDLE : ST_FETCH;
                ST_FETCH:   state_d = ST_DECODE;
                ST_DECODE:  state_d = ST_EXECUTE;
                ST_EXECUTE: state_d = halt ? ST_IDLE : ST_FETCH;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state      = state_q;
        fetch      = (state_q == ST_FETCH);
        decode     = (state_q == ST_DECODE);
        execute    = (state_q == ST_EXECUTE);
        instr_done = (state_q == ST_EXECUTE) && en;
    end

`ifdef FDE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (instr_done) begin
            instr_count <= instr_count + 1'b1;
        end
    end
`else
    // COUNT_W only sizes the counter; referenced so both builds share one parameter list
    if (COUNT_W < 1) begin : g_count_w_unused
    end
`endif

endmodule

// File: tb/tb_fde_machine.sv
// Scoreboard bench for fde_machine: driver queues expected phase/count per cycle,
// negedge monitor pops and compares.
module tb_fde_machine;

    localparam int CW = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_DECODE = 2'b10;
    localparam logic [1:0] S_EXEC = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          halt;
    logic [1:0]    state;
    logic          fetch;
    logic          decode;
    logic          execute;
    logic          instr_done;
`ifdef FDE_COUNT_EN
    logic [CW-1:0] instr_count;
`endif

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    fde_machine #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .halt       (halt),
        .state      (state),
        .fetch      (fetch),
        .decode     (decode),
        .execute    (execute),
        .instr_done (instr_done)
`ifdef FDE_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endfunction

    // expectation describes the DUT after this edge; e/h are applied for the next edge
    task automatic cyc(input logic e, input logic h, input logic [1:0] es, input int ec);
        @(posedge clk);
        #1;
        en   = e;
        halt = h;
        exp_q.push_back('{st: es, en: e, cnt: 16'(ec)});
    endtask

    // reset pulsed between edges while in EXECUTE; checked before any further rising edge
    task automatic cyc_rst(input logic e);
        @(posedge clk);
        #1;
        en   = e;
        halt = 1'b0;
        #1 reset = 1'b1;
        exp_q.push_back('{st: S_IDLE, en: e, cnt: 16'd0});
        #5 reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("state", int'(state), int'(x.st));
                chk("strobes", int'({fetch, decode, execute}),
                    int'({x.st == S_FETCH, x.st == S_DECODE, x.st == S_EXEC}));
                chk("instr_done", int'(instr_done), int'((x.st == S_EXEC) && x.en));
`ifdef FDE_COUNT_EN
                chk("instr_count", int'(instr_count), int'(x.cnt[CW-1:0]));
`endif
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset = 1'b1;
        en    = 1'b0;
        halt  = 1'b0;

        // reset state, and reset held across an enabled edge
        cyc(1, 0, S_IDLE, 0);
        cyc(1, 0, S_IDLE, 0);
        #2 reset = 1'b0;

        // free-running: two instructions back to back
        cyc(1, 0, S_FETCH, 0);
        cyc(1, 0, S_DECODE, 0);
        cyc(1, 0, S_EXEC, 0);
        cyc(1, 0, S_FETCH, 1);
        cyc(1, 0, S_DECODE, 1);
        cyc(1, 0, S_EXEC, 1);
        cyc(1, 0, S_FETCH, 2);

        // freeze in DECODE for 5 edges, halt toggled to show it is ignored
        cyc(0, 1, S_DECODE, 2);
        for (int i = 0; i < 4; i++) cyc(0, 1, S_DECODE, 2);
        cyc(1, 0, S_DECODE, 2);
        cyc(1, 0, S_EXEC, 2);

        // halt raised in FETCH: instruction completes, then parks in IDLE
        cyc(1, 1, S_FETCH, 3);
        cyc(1, 1, S_DECODE, 3);
        cyc(1, 1, S_EXEC, 3);
        cyc(1, 1, S_IDLE, 4);
        cyc(1, 1, S_IDLE, 4);
        cyc(1, 0, S_IDLE, 4);
        cyc(1, 0, S_FETCH, 4);

        // en low while in EXECUTE: no retire until en returns
        cyc(1, 0, S_DECODE, 4);
        cyc(0, 0, S_EXEC, 4);
        cyc(1, 0, S_EXEC, 4);
        cyc(1, 0, S_FETCH, 5);

        // asynchronous reset mid-EXECUTE
        cyc(1, 0, S_DECODE, 5);
        cyc_rst(1);
        cyc(1, 0, S_FETCH, 0);

        // 16 instructions: counter wraps 4'hF -> 4'h0
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, S_DECODE, i);
            cyc(1, 0, S_EXEC, i);
            cyc(1, 0, S_FETCH, (i + 1) % 16);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
